// File: rtl/mips_pkg.sv
// Shared encodings for the multicycle MIPS control path: opcodes, FSM states,
// datapath mux selects and the packed control bundle.
package mips_pkg;

    localparam logic [5:0] RTYPE = 6'd0;
    localparam logic [5:0] BEQ   = 6'd4;
    localparam logic [5:0] ADDI  = 6'd8;
    localparam logic [5:0] LUI   = 6'd15;
    localparam logic [5:0] LW    = 6'd35;
    localparam logic [5:0] SW    = 6'd43;

    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        MEM_ADDR = 4'd2,
        MEM_RD   = 4'd3,
        MEM_WB   = 4'd4,
        MEM_WR   = 4'd5,
        EXEC     = 4'd6,
        R_WB     = 4'd7,
        BRANCH   = 4'd8,
        I_EXEC   = 4'd9,
        I_WB     = 4'd10
    } state_t;

    typedef enum logic [1:0] {
        ALU_ADD   = 2'd0,
        ALU_SUB   = 2'd1,
        ALU_FUNCT = 2'd2,
        ALU_LUI   = 2'd3
    } alu_op_t;

    typedef enum logic [1:0] {
        SRCB_REGB    = 2'd0,
        SRCB_FOUR    = 2'd1,
        SRCB_IMM     = 2'd2,
        SRCB_IMM_SH2 = 2'd3
    } alu_src_b_t;

    typedef enum logic {
        PCSRC_ALU    = 1'b0,
        PCSRC_ALUOUT = 1'b1
    } pc_source_t;

    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       ir_write;
        logic       i_or_d;
        logic       mem_read;
        logic       mem_write;
        logic       reg_write;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       alu_src_a;
        alu_src_b_t alu_src_b;
        alu_op_t    alu_op;
        pc_source_t pc_source;
        logic       instr_done;
        logic       illegal;
        logic       mem_err;
    } ctrl_t;

    function automatic logic is_wait_state(input state_t s);
        return (s == FETCH) || (s == MEM_RD) || (s == MEM_WR);
    endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Counts consecutive memory wait cycles and flags the cycle that reaches TIMEOUT.
module mem_wait_timer #(
    parameter int unsigned TIMEOUT = 15
) (
    input  logic clk,
    input  logic rst_n,
    input  logic waiting,
    input  logic clear,
    output logic expired
);

    logic [3:0] count;

    assign expired = waiting && (count == 4'(TIMEOUT - 1));

    // Expiry restarts the count even when the FSM stays in FETCH.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clear || expired || !waiting) begin
            count <= '0;
        end else begin
            count <= count + 4'd1;
        end
    end

endmodule

// File: rtl/multicycle_control.sv
// Multicycle MIPS control FSM: drives datapath strobes per state, counts
// completed instructions and aborts stalled memory accesses.
module multicycle_control
    import mips_pkg::*;
#(
    parameter int unsigned TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [5:0]  opcode,
    input  logic        mem_ready,
    output logic        pc_write,
    output logic        pc_write_cond,
    output logic        ir_write,
    output logic        i_or_d,
    output logic        mem_read,
    output logic        mem_write,
    output logic        reg_write,
    output logic        reg_dst,
    output logic        mem_to_reg,
    output logic        alu_src_a,
    output logic [1:0]  alu_src_b,
    output logic [1:0]  alu_op,
    output logic        pc_source,
    output logic        instr_done,
    output logic        illegal,
    output logic        mem_err,
    output logic [31:0] instr_count,
    output logic [3:0]  state
);

    state_t cur, nxt;
    ctrl_t  ctrl, ctrl_gated;
    logic   waiting, expired, clear;

    assign waiting = is_wait_state(cur) && !mem_ready;
    assign clear   = (nxt != cur);

    mem_wait_timer #(.TIMEOUT(TIMEOUT)) u_wait_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .waiting (waiting),
        .clear   (clear),
        .expired (expired)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur <= FETCH;
        end else begin
            cur <= nxt;
        end
    end

    always_comb begin
        ctrl = '0;
        nxt  = cur;
        case (cur)
            FETCH: begin
                if (expired) begin
                    ctrl.mem_err = 1'b1;
                end else begin
                    ctrl.mem_read  = 1'b1;
                    ctrl.alu_src_b = SRCB_FOUR;
                    if (mem_ready) begin
                        ctrl.ir_write = 1'b1;
                        ctrl.pc_write = 1'b1;
                        nxt           = DECODE;
                    end
                end
            end
            DECODE: begin
                ctrl.alu_src_b = SRCB_IMM_SH2;
                ctrl.alu_op    = ALU_ADD;
                case (opcode)
                    LW, SW:    nxt = MEM_ADDR;
                    RTYPE:     nxt = EXEC;
                    BEQ:       nxt = BRANCH;
                    ADDI, LUI: nxt = I_EXEC;
                    default: begin
                        ctrl.illegal = 1'b1;
                        nxt          = FETCH;
                    end
                endcase
            end
            MEM_ADDR: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_IMM;
                ctrl.alu_op    = ALU_ADD;
                nxt            = (opcode == LW) ? MEM_RD : MEM_WR;
            end
            MEM_RD: begin
                if (expired) begin
                    ctrl.mem_err = 1'b1;
                    nxt          = FETCH;
                end else begin
                    ctrl.mem_read = 1'b1;
                    ctrl.i_or_d   = 1'b1;
                    if (mem_ready) nxt = MEM_WB;
                end
            end
            MEM_WB: begin
                ctrl.reg_write  = 1'b1;
                ctrl.mem_to_reg = 1'b1;
                ctrl.instr_done = 1'b1;
                nxt             = FETCH;
            end
            MEM_WR: begin
                if (expired) begin
                    ctrl.mem_err = 1'b1;
                    nxt          = FETCH;
                end else begin
                    ctrl.mem_write = 1'b1;
                    ctrl.i_or_d    = 1'b1;
                    if (mem_ready) begin
                        ctrl.instr_done = 1'b1;
                        nxt             = FETCH;
                    end
                end
            end
            EXEC: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_REGB;
                ctrl.alu_op    = ALU_FUNCT;
                nxt            = R_WB;
            end
            R_WB: begin
                ctrl.reg_write  = 1'b1;
                ctrl.reg_dst    = 1'b1;
                ctrl.instr_done = 1'b1;
                nxt             = FETCH;
            end
            BRANCH: begin
                ctrl.alu_src_a     = 1'b1;
                ctrl.alu_src_b     = SRCB_REGB;
                ctrl.alu_op        = ALU_SUB;
                ctrl.pc_write_cond = 1'b1;
                ctrl.pc_source     = PCSRC_ALUOUT;
                ctrl.instr_done    = 1'b1;
                nxt                = FETCH;
            end
            I_EXEC: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_IMM;
                ctrl.alu_op    = (opcode == LUI) ? ALU_LUI : ALU_ADD;
                nxt            = I_WB;
            end
            I_WB: begin
                ctrl.reg_write  = 1'b1;
                ctrl.instr_done = 1'b1;
                nxt             = FETCH;
            end
            default: nxt = FETCH;
        endcase
    end

    // Reset must also silence the Mealy strobes that FETCH derives from mem_ready.
    assign ctrl_gated = rst_n ? ctrl : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            instr_count <= '0;
        end else if (ctrl.instr_done) begin
            instr_count <= instr_count + 32'd1;
        end
    end

    assign pc_write      = ctrl_gated.pc_write;
    assign pc_write_cond = ctrl_gated.pc_write_cond;
    assign ir_write      = ctrl_gated.ir_write;
    assign i_or_d        = ctrl_gated.i_or_d;
    assign mem_read      = ctrl_gated.mem_read;
    assign mem_write     = ctrl_gated.mem_write;
    assign reg_write     = ctrl_gated.reg_write;
    assign reg_dst       = ctrl_gated.reg_dst;
    assign mem_to_reg    = ctrl_gated.mem_to_reg;
    assign alu_src_a     = ctrl_gated.alu_src_a;
    assign alu_src_b     = ctrl_gated.alu_src_b;
    assign alu_op        = ctrl_gated.alu_op;
    assign pc_source     = ctrl_gated.pc_source;
    assign instr_done    = ctrl_gated.instr_done;
    assign illegal       = ctrl_gated.illegal;
    assign mem_err       = ctrl_gated.mem_err;
    assign state         = cur;

endmodule

// File: doc/multicycle_control.md
MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 SHALL have parameter TIMEOUT, default 15 (range 2..15), the maximum number of memory wait cycles before abort.
REQ-002 SHALL have ports, one per line:
- clk  in  1  sole clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- opcode  in  6  IR[31:26]; stable from DECODE until instruction end.
- mem_ready  in  1  memory handshake; current access completes this cycle.
- pc_write, pc_write_cond, ir_write  out  1 each  PC / IR write strobes.
- i_or_d, mem_read, mem_write  out  1 each  memory address select (0=PC, 1=ALUOut) and access strobes.
- reg_write, reg_dst, mem_to_reg  out  1 each  register-file controls.
- alu_src_a  out  1  ALU A select: 0=PC, 1=regA.
- alu_src_b  out  2  ALU B select: 0=regB, 1=const 4, 2=sign-ext imm, 3=sign-ext imm<<2.
- alu_op  out  2  ALU op: 0=add, 1=sub, 2=funct, 3=lui.
- pc_source  out  1  PC source: 0=ALU result, 1=ALUOut.
- instr_done  out  1  one-cycle pulse on the final cycle of a completed instruction.
- illegal  out  1  one-cycle pulse for an unsupported opcode.
- mem_err  out  1  one-cycle pulse on memory timeout.
- instr_count  out  32  count of completed instructions.
- state  out  4  current state, for debug.

Function
REQ-003 SHALL implement the states FETCH=0, DECODE=1, MEM_ADDR=2, MEM_RD=3, MEM_WB=4, MEM_WR=5, EXEC=6, R_WB=7, BRANCH=8, I_EXEC=9, I_WB=10; codes 11..15 SHALL go to FETCH.
REQ-004 Every output not listed for a state SHALL be 0 in that state.
REQ-005 FETCH SHALL drive mem_read=1, alu_src_b=1, and SHALL wait until mem_ready.
- With mem_ready=1: ir_write=1, pc_write=1 in that same cycle (Mealy), then go to DECODE.
REQ-006 DECODE SHALL drive alu_src_b=3, alu_op=0 (branch target to ALUOut) and SHALL branch on opcode:
- 35 or 43 -> MEM_ADDR.
- 0 -> EXEC.
- 4 -> BRANCH.
- 8 or 15 -> I_EXEC.
- Any other -> FETCH, with illegal=1 in that cycle; the instruction is not counted.
REQ-007 MEM_ADDR SHALL drive alu_src_a=1, alu_src_b=2, alu_op=0, then go to MEM_RD if opcode=35, otherwise to MEM_WR.
REQ-008 MEM_RD SHALL drive mem_read=1, i_or_d=1, and SHALL go to MEM_WB when mem_ready=1.
REQ-009 MEM_WB SHALL drive reg_write=1, mem_to_reg=1, reg_dst=0, then go to FETCH.
REQ-010 MEM_WR SHALL drive mem_write=1, i_or_d=1, and SHALL go to FETCH when mem_ready=1.
REQ-011 EXEC SHALL drive alu_src_a=1, alu_src_b=0, alu_op=2, then go to R_WB; R_WB SHALL drive reg_write=1, reg_dst=1, then go to FETCH.
REQ-012 BRANCH SHALL drive alu_src_a=1, alu_src_b=0, alu_op=1, pc_write_cond=1, pc_source=1, then go to FETCH.
REQ-013 I_EXEC SHALL drive alu_src_a=1, alu_src_b=2, alu_op=0 for opcode 8 or 3 for opcode 15, then go to I_WB; I_WB SHALL drive reg_write=1, reg_dst=0, then go to FETCH.
REQ-014 instr_done SHALL pulse in MEM_WB, R_WB, BRANCH, I_WB and in the MEM_WR cycle where mem_ready=1.
- instr_count SHALL increment by 1 on the following edge and SHALL wrap from 0xFFFFFFFF to 0.
REQ-015 With zero-wait memory, instruction latency SHALL be lw=5, sw=4, R-type=4, addi/lui=4, beq=3 cycles; each wait cycle adds 1.
REQ-016 A wait counter SHALL count consecutive mem_ready=0 cycles in FETCH, MEM_RD and MEM_WR, and SHALL clear on state change.
- On the TIMEOUT-th consecutive wait cycle: mem_err=1, no strobes, next state FETCH; the instruction is not counted and the PC is unchanged.
REQ-017 mem_ready in any non-waiting state SHALL be ignored.

Reset
REQ-018 rst_n=0 SHALL immediately force state=FETCH, wait counter=0, instr_count=0.
REQ-019 While rst_n=0 all outputs SHALL be forced to 0, including the Mealy strobes.
REQ-020 Reset asserted mid-instruction SHALL abandon the instruction with no further strobes.
REQ-021 After rst_n rises, the first edge SHALL begin FETCH.

Structure
REQ-022 A shared package mips_pkg SHALL hold the opcode constants (RTYPE=0, BEQ=4, ADDI=8, LUI=15, LW=35, SW=43), the state encoding, and the alu_op, alu_src_b and pc_source encodings.
REQ-023 The wait counter and timeout compare SHALL be a sub-module mem_wait_timer (inputs clk, rst_n, waiting, clear; output expired).

Verification
REQ-024 Reset then lw (opcode 35) with mem_ready always 1 -> states 0,1,2,3,4; reg_write&mem_to_reg in cycle 5; instr_count=1.
REQ-025 beq (opcode 4) -> pc_write_cond=1, pc_source=1, alu_op=1 in cycle 3; instr_done in the same cycle.
REQ-026 sw with mem_ready low 3 cycles in MEM_WR -> mem_write held 4 cycles; instr_done on the 4th; latency 7.
REQ-027 mem_ready held 0 in FETCH, TIMEOUT=15 -> mem_err on the 15th cycle; state returns to FETCH; no ir_write; count unchanged.
REQ-028 opcode 2 at DECODE -> illegal pulse; next state FETCH; instr_count unchanged.
REQ-029 rst_n pulled low in EXEC -> all outputs 0 at once; state=0, instr_count=0; a clean R-type completes after release.
